// File: rtl/move_fsm.sv
// rtl/move_fsm.sv - MOVE instruction control FSM (Ri <- Rj over the shared bus)
// Sequences source read strobe, destination write strobe, then a next-instruction pulse.
module move_fsm #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] Ri,
    input  logic [IDX_W-1:0] Rj,
    output logic             start_next_I,
    output logic             R0_write,
    output logic             R0_read,
    output logic             R1_write,
    output logic             R1_read,
    output logic             R2_write,
    output logic             R2_read,
    output logic             R3_write,
    output logic             R3_read
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [3:0]       rd_vec, wr_vec;
    logic             src_valid, dst_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dst_d   = Ri;
                    src_d   = Rj;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Indices above 3 address no register: the strobe is suppressed but sequencing continues.
    assign src_valid = ((src_q >> 2) == '0);
    assign dst_valid = ((dst_q >> 2) == '0);

    always_comb begin
        rd_vec = '0;
        wr_vec = '0;
        if (state_q == S_READ && src_valid) begin
            rd_vec[src_q[1:0]] = 1'b1;
        end
        if (state_q == S_WRITE && dst_valid) begin
            wr_vec[dst_q[1:0]] = 1'b1;
        end
    end

    assign start_next_I = (state_q == S_DONE);
    assign R0_read      = rd_vec[0];
    assign R1_read      = rd_vec[1];
    assign R2_read      = rd_vec[2];
    assign R3_read      = rd_vec[3];
    assign R0_write     = wr_vec[0];
    assign R1_write     = wr_vec[1];
    assign R2_write     = wr_vec[2];
    assign R3_write     = wr_vec[3];

endmodule

// File: tb/tb_move_fsm.sv
// tb/tb_move_fsm.sv - self-checking bench for move_fsm against a cycle-count reference model
module tb_move_fsm;

    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W-1:0] Ri = '0;
    logic [IDX_W-1:0] Rj = '0;
    logic start_next_I;
    logic R0_write, R0_read, R1_write, R1_read;
    logic R2_write, R2_read, R3_write, R3_read;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cycles elapsed since the move was accepted (0 = idle).
    int busy = 0;
    int m_dst = 0;
    int m_src = 0;

    always #5 clk = ~clk;

    move_fsm #(.IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .Ri(Ri), .Rj(Rj),
        .start_next_I(start_next_I),
        .R0_write(R0_write), .R0_read(R0_read),
        .R1_write(R1_write), .R1_read(R1_read),
        .R2_write(R2_write), .R2_read(R2_read),
        .R3_write(R3_write), .R3_read(R3_read)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector layout: {start_next, R3w, R2w, R1w, R0w, R3r, R2r, R1r, R0r}
    function automatic logic [8:0] model_out();
        logic [8:0] v;
        v = '0;
        if (busy == 1 && m_src < 4) v[m_src] = 1'b1;
        if (busy == 2 && m_dst < 4) v[4 + m_dst] = 1'b1;
        if (busy == 3) v[8] = 1'b1;
        return v;
    endfunction

    task automatic cycle(input string tag, input logic r, input logic s,
                         input int ri, input int rj);
        logic [8:0] dut_v;
        reset = r;
        start = s;
        Ri    = IDX_W'(ri);
        Rj    = IDX_W'(rj);
        @(posedge clk);
        if (r) begin
            busy = 0; m_dst = 0; m_src = 0;
        end else if (busy == 0) begin
            if (s) begin
                busy = 1; m_dst = ri; m_src = rj;
            end
        end else begin
            busy = (busy + 1) % 4;
        end
        @(negedge clk);
        dut_v = {start_next_I, R3_write, R2_write, R1_write, R0_write,
                 R3_read, R2_read, R1_read, R0_read};
        check(tag, 32'(dut_v), 32'(model_out()));
        check({tag, "_excl"},
              32'((|dut_v[7:4]) && (|dut_v[3:0])), 32'd0);
    endtask

    initial begin
        // Reset then idle
        cycle("reset", 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 1'b0, 0, 0);

        // R3 -> R0
        cycle("mv03", 1'b0, 1'b1, 0, 3);
        for (int i = 0; i < 4; i++) cycle("mv03", 1'b0, 1'b0, 0, 3);

        // Same-register no-op move
        cycle("mv22", 1'b0, 1'b1, 2, 2);
        for (int i = 0; i < 4; i++) cycle("mv22", 1'b0, 1'b0, 2, 2);

        // Indices change and start re-pulsed while busy: ignored
        cycle("relatch", 1'b0, 1'b1, 1, 0);
        cycle("relatch", 1'b0, 1'b1, 3, 0);
        for (int i = 0; i < 4; i++) cycle("relatch", 1'b0, 1'b0, 3, 0);

        // Reset during WRITE aborts, then a normal move
        cycle("abort", 1'b0, 1'b1, 3, 1);
        cycle("abort", 1'b0, 1'b0, 3, 1);
        cycle("abort", 1'b1, 1'b0, 3, 1);
        cycle("abort", 1'b0, 1'b0, 3, 1);
        cycle("after", 1'b0, 1'b1, 1, 2);
        for (int i = 0; i < 4; i++) cycle("after", 1'b0, 1'b0, 1, 2);

        // Out-of-range indices, then start held high
        cycle("oor", 1'b0, 1'b1, 5, 7);
        for (int i = 0; i < 3; i++) cycle("oor", 1'b0, 1'b0, 5, 7);
        for (int i = 0; i < 8; i++) cycle("hold", 1'b0, 1'b1, 2, 1);
        for (int i = 0; i < 2; i++) cycle("hold", 1'b0, 1'b0, 2, 1);

        // Randomized traffic, mostly in-range indices with occasional wide values
        for (int i = 0; i < 2000; i++) begin
            int ri, rj;
            ri = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
            rj = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
            cycle("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), ri, rj);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
